typec_rx_ctrl: RTL
==================

Name: typec_rx_ctrl

Overview:
- Packet-level sequencer for the bit-serial Type-C byte receiver (typec_rxf).
- Arms the receiver by driving its fire input, tracks its byte framing from the same serial line, and samples the receiver's parallel byte output.
- Parses header/length/payload/checksum and streams payload bytes to the frame logic.
- Recovers the receiver after timeout or error with a one-cycle reset pulse.

Parameters:
- HDR, 8'hA5, required first byte after the sync bit.
- MAX_LEN, 8'd64, largest legal payload length; LEN = 0 or LEN > MAX_LEN is an error.
- TIMEOUT, 16'd4096, maximum cycles spent in HUNT before abort.
- GAP, 2, idle cycles between disarm and re-arm; minimum 2.

Ports:
- clk, input, 1, system clock, shared with typec_rxf.
- rst, input, 1, asynchronous active-low reset.
- en, input, 1, level enable; when high, the block re-arms continuously.
- din, input, 1, serial line; same net as typec_rxf din.
- rxf_dout, input, 8, typec_rxf dout.
- rxf_fire, output, 1, drives typec_rxf fire.
- rxf_rst, output, 1, active-high one-cycle reset pulse to typec_rxf.
- pkt_data, output, 8, payload byte.
- pkt_valid, output, 1, one-cycle strobe qualifying pkt_data.
- pkt_done, output, 1, one-cycle end-of-packet strobe.
- pkt_err, output, 2, status qualified by pkt_done: 0 ok, 1 bad header, 2 bad length, 3 checksum or timeout.
- busy, output, 1, high in any state other than IDLE or GAP.

Behaviour:
- Reset (rst low, async): state IDLE. All outputs 0. Counters 0. rxf_rst is held at 0 during reset, because typec_rxf sees the same board reset.
- States: IDLE, ARM, HUNT, BYTE, ABORT, GAP.
- IDLE: if en then ARM.
- ARM (1 cycle): rxf_fire goes high; next state HUNT. The receiver moves WAIT->WORK on the same edge.
- HUNT:
  - On an edge with din = 1: go to BYTE, bit_cnt = 0, byte_idx = 0. The receiver enters R0 on that edge.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT-1: go to ABORT with err 3.
- BYTE:
  - bit_cnt counts 0..7, mirroring receiver states R0..R7.
  - The cycle after bit_cnt = 7, rxf_dout holds the completed byte. The block samples it on that edge (the sample strobe).
  - Byte sequence: byte 0 = header, byte 1 = LEN, bytes 2..LEN+1 = payload, byte LEN+2 = checksum.
  - Checksum = XOR of LEN and all payload bytes.
- Header check: header != HDR -> ABORT, err 1.
- Length check: LEN = 0 or LEN > MAX_LEN -> ABORT, err 2. Both checks are evaluated on the sample strobe.
- Payload: each payload byte drives pkt_data and pulses pkt_valid for 1 cycle, on the cycle after its sample strobe.
- Last byte (checksum):
  - rxf_fire is cleared on the edge where bit_cnt goes 6->7. Fire is therefore low while the receiver is in R7, so it exits via DONE->WAIT.
  - On the checksum sample strobe: pkt_done pulses with err 0 (match) or 3 (mismatch). Next state GAP.
- ABORT (1 cycle):
  - rxf_fire = 0, rxf_rst = 1, pkt_done = 1, pkt_err = code.
  - A reset is mandatory here: typec_rxf in WORK ignores fire and otherwise hangs.
  - Next state GAP.
- GAP: count GAP cycles (receiver IDLE/DONE->WAIT settle), then go to ARM if en, else IDLE.
- en dropping mid-packet: the packet completes normally; no re-arm follows.
- rxf_fire never rises outside ARM, and is never high in GAP or IDLE.
- pkt_valid and pkt_done never assert in the same cycle.
- Throughput: one byte per 8 cycles.
- Latency: last bit of a byte to pkt_valid = 2 cycles.

Test Plan:
- Good packet: en=1; line carries sync, A5, 03, 11, 22, 33, checksum 03^11^22^33 = 0x03 (MSB first). Required: pkt_valid x3 with data 11, 22, 33, spaced 8 cycles apart. Then pkt_done with err 0. Fire is low during the final R7, and the receiver returns to WAIT.
- Bad header: sync, 5A. Required: pkt_done with err 1, a single-cycle rxf_rst, then re-arm after GAP. No pkt_valid.
- Bad length: A5, 00. Then A5, 41 with MAX_LEN = 64. Required: err 2 in both cases.
- Checksum error: A5, 01, 7F, 00. Required: 1 pkt_valid (7F), then pkt_done with err 3.
- Timeout: din held 0 with TIMEOUT = 16. Required: ABORT after exactly 16 HUNT cycles, err 3, rxf_rst pulse.
- Async reset asserted mid-payload: all outputs go to 0 immediately. After release, IDLE -> ARM on the next cycle with en = 1.

Source files
------------

// File: rtl/typec_rx_ctrl.sv
// typec_rx_ctrl
// Packet-level sequencer for the bit-serial Type-C byte receiver (typec_rxf).
// It arms the receiver with rxf_fire and follows the receiver's bit framing
// from the shared serial line. It samples each completed byte on rxf_dout and
// parses the frame: header, length, payload, then checksum. Payload bytes are
// streamed out with a one-cycle valid strobe. After a header error, a length
// error or a hunt timeout it pulses rxf_rst for one cycle.
//
// Ports:
//   clk       system clock, shared with typec_rxf
//   rst       asynchronous active-low reset
//   en        level enable; while high the block keeps re-arming
//   din       serial line (same net as typec_rxf din)
//   rxf_dout  typec_rxf parallel byte output
//   rxf_fire  arm request to typec_rxf
//   rxf_rst   one-cycle active-high reset pulse to typec_rxf
//   pkt_data  payload byte, qualified by pkt_valid
//   pkt_valid one-cycle payload strobe
//   pkt_done  one-cycle end-of-packet strobe
//   pkt_err   status qualified by pkt_done: 0 ok, 1 header, 2 length, 3 checksum/timeout
//   busy      high in ARM, HUNT, BYTE and ABORT
module typec_rx_ctrl #(
  parameter logic [7:0]  HDR     = 8'hA5,
  parameter logic [7:0]  MAX_LEN = 8'd64,
  parameter logic [15:0] TIMEOUT = 16'd4096,
  parameter int unsigned GAP     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       din,
  input  logic [7:0] rxf_dout,
  output logic       rxf_fire,
  output logic       rxf_rst,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  output logic       pkt_done,
  output logic [1:0] pkt_err,
  output logic       busy
);

  localparam logic [15:0] TMO_LAST = TIMEOUT - 16'd1;
  localparam logic [7:0]  GAP_LAST = 8'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_HUNT  = 3'd2,
    S_BYTE  = 3'd3,
    S_ABORT = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  state_t      state_r, state_s;
  logic [2:0]  bit_cnt_r, bit_cnt_s;
  logic [7:0]  byte_idx_r, byte_idx_s;
  logic        strobe_r, strobe_s;
  logic [7:0]  len_r, len_s;
  logic [7:0]  csum_r, csum_s;
  logic [15:0] tmo_cnt_r, tmo_cnt_s;
  logic [7:0]  gap_cnt_r, gap_cnt_s;
  logic [7:0]  data_s;
  logic        valid_s, done_s, fire_s, rrst_s, busy_s, fire_clr_s;
  logic [1:0]  err_s;

  // Next-state, counter and output decode
  always_comb begin
    state_s    = state_r;
    bit_cnt_s  = bit_cnt_r;
    byte_idx_s = byte_idx_r;
    strobe_s   = 1'b0;
    len_s      = len_r;
    csum_s     = csum_r;
    tmo_cnt_s  = tmo_cnt_r;
    gap_cnt_s  = gap_cnt_r;
    data_s     = pkt_data;
    valid_s    = 1'b0;
    done_s     = 1'b0;
    err_s      = 2'd0;
    fire_clr_s = 1'b0;

    case (state_r)
      S_IDLE: begin
        if (en) begin
          state_s = S_ARM;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ARM: begin
        state_s   = S_HUNT;
        tmo_cnt_s = 16'd0;
      end
      S_HUNT: begin
        if (din) begin
          // Sync bit: the receiver enters R0 on this same edge.
          state_s    = S_BYTE;
          bit_cnt_s  = 3'd0;
          byte_idx_s = 8'd0;
          tmo_cnt_s  = 16'd0;
        end else if (tmo_cnt_r == TMO_LAST) begin
          state_s = S_ABORT;
          done_s  = 1'b1;
          err_s   = 2'd3;
        end else begin
          tmo_cnt_s = tmo_cnt_r + 16'd1;
        end
      end
      S_BYTE: begin
        bit_cnt_s = bit_cnt_r + 3'd1;
        // The byte completed by R7 is visible on rxf_dout one cycle later.
        strobe_s  = (bit_cnt_r == 3'd7);
        // Drop fire before R7 of the checksum byte so the receiver leaves via DONE.
        if ((bit_cnt_r == 3'd6) && (byte_idx_r >= 8'd2) && (byte_idx_r == len_r + 8'd2)) begin
          fire_clr_s = 1'b1;
        end else begin
          fire_clr_s = 1'b0;
        end
        if (strobe_r) begin
          byte_idx_s = byte_idx_r + 8'd1;
          if (byte_idx_r == 8'd0) begin
            if (rxf_dout != HDR) begin
              state_s = S_ABORT;
              done_s  = 1'b1;
              err_s   = 2'd1;
            end else begin
              state_s = S_BYTE;
            end
          end else if (byte_idx_r == 8'd1) begin
            if ((rxf_dout == 8'd0) || (rxf_dout > MAX_LEN)) begin
              state_s = S_ABORT;
              done_s  = 1'b1;
              err_s   = 2'd2;
            end else begin
              len_s  = rxf_dout;
              csum_s = rxf_dout;
            end
          end else if (byte_idx_r == len_r + 8'd2) begin
            state_s   = S_GAP;
            gap_cnt_s = 8'd0;
            done_s    = 1'b1;
            err_s     = (csum_r == rxf_dout) ? 2'd0 : 2'd3;
          end else begin
            data_s  = rxf_dout;
            valid_s = 1'b1;
            csum_s  = csum_r ^ rxf_dout;
          end
        end else begin
          state_s = S_BYTE;
        end
      end
      S_ABORT: begin
        state_s   = S_GAP;
        gap_cnt_s = 8'd0;
      end
      S_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_s = en ? S_ARM : S_IDLE;
        end else begin
          gap_cnt_s = gap_cnt_r + 8'd1;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    // Fire only rises on entry to ARM and is held through HUNT/BYTE.
    fire_s = (state_s == S_ARM) ||
             (rxf_fire && ((state_s == S_HUNT) || (state_s == S_BYTE)) && !fire_clr_s);
    rrst_s = (state_s == S_ABORT);
    busy_s = (state_s == S_ARM) || (state_s == S_HUNT) ||
             (state_s == S_BYTE) || (state_s == S_ABORT);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= S_IDLE;
      bit_cnt_r  <= 3'd0;
      byte_idx_r <= 8'd0;
      strobe_r   <= 1'b0;
      len_r      <= 8'd0;
      csum_r     <= 8'd0;
      tmo_cnt_r  <= 16'd0;
      gap_cnt_r  <= 8'd0;
      rxf_fire   <= 1'b0;
      rxf_rst    <= 1'b0;
      pkt_data   <= 8'd0;
      pkt_valid  <= 1'b0;
      pkt_done   <= 1'b0;
      pkt_err    <= 2'd0;
      busy       <= 1'b0;
    end else begin
      state_r    <= state_s;
      bit_cnt_r  <= bit_cnt_s;
      byte_idx_r <= byte_idx_s;
      strobe_r   <= strobe_s;
      len_r      <= len_s;
      csum_r     <= csum_s;
      tmo_cnt_r  <= tmo_cnt_s;
      gap_cnt_r  <= gap_cnt_s;
      rxf_fire   <= fire_s;
      rxf_rst    <= rrst_s;
      pkt_data   <= data_s;
      pkt_valid  <= valid_s;
      pkt_done   <= done_s;
      pkt_err    <= err_s;
      busy       <= busy_s;
    end
  end

endmodule
